// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul address generator.
// Pipeline depths here set the mac_en/wr_en delays.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DIM_WIDTH  = 4;

    localparam int RD_LAT  = 1;
    localparam int MAC_LAT = 1;
    localparam int WR_LAT  = RD_LAT + MAC_LAT;

endpackage

// File: rtl/matmul_addr_gen_if.sv
// Control, operand-read, MAC-strobe and C-write bundle
// of the matmul address generator.
interface matmul_addr_gen_if
    import matmul_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DIM_WIDTH  = DEF_DIM_WIDTH
);

    logic                  start;
    logic                  stall;
    logic [DIM_WIDTH-1:0]  dim_m;
    logic [DIM_WIDTH-1:0]  dim_n;
    logic [DIM_WIDTH-1:0]  dim_p;
    logic [ADDR_WIDTH-1:0] base_a;
    logic [ADDR_WIDTH-1:0] base_b;
    logic [ADDR_WIDTH-1:0] base_c;
    logic                  busy;
    logic                  done;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic                  mac_en;
    logic                  mac_first;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] addr_c;

    modport master (
        output start, stall,
        output dim_m, dim_n, dim_p,
        output base_a, base_b, base_c,
        input  busy, done,
        input  rd_en, addr_a, addr_b,
        input  mac_en, mac_first,
        input  wr_en, addr_c
    );

    modport slave (
        input  start, stall,
        input  dim_m, dim_n, dim_p,
        input  base_a, base_b, base_c,
        output busy, done,
        output rd_en, addr_a, addr_b,
        output mac_en, mac_first,
        output wr_en, addr_c
    );

endinterface

// File: rtl/loop_counter.sv
// Wrapping loop index: counts 0..limit-1, flags the last value.
module loop_counter #(
    parameter int DIM_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 inc,
    input  logic [DIM_WIDTH-1:0] limit,
    output logic [DIM_WIDTH-1:0] value,
    output logic                 last
);

    assign last = (value == limit - DIM_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= last ? '0 : value + DIM_WIDTH'(1);
        end
    end

endmodule

// File: rtl/matmul_addr_gen.sv
// i/j/k loop-nest walker issuing A/B reads, MAC strobes and C writes
// for C = A*B with row-major matrices; addresses built incrementally.
module matmul_addr_gen
    import matmul_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DIM_WIDTH  = DEF_DIM_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    matmul_addr_gen_if.slave bus
);

    localparam logic [WR_LAT-1:0] WR_TAIL = WR_LAT'(1) << (WR_LAT - 1);

    state_t                state;
    logic [DIM_WIDTH-1:0]  m_q;
    logic [DIM_WIDTH-1:0]  n_q;
    logic [DIM_WIDTH-1:0]  p_q;
    logic [ADDR_WIDTH-1:0] bb_q;
    logic [ADDR_WIDTH-1:0] ra;
    logic [ADDR_WIDTH-1:0] rb;
    logic [ADDR_WIDTH-1:0] rc;
    logic                  rd_q;
    logic                  busy_q;
    logic                  done_q;
    logic [RD_LAT-1:0]     mac_sr;
    logic [RD_LAT-1:0]     first_sr;
    logic [WR_LAT-1:0]     wr_sr;

    logic [DIM_WIDTH-1:0]  k;
    logic [DIM_WIDTH-1:0]  j;
    logic [DIM_WIDTH-1:0]  i;
    logic                  k_last;
    logic                  j_last;
    logic                  i_last;
    logic                  go;
    logic                  step;
    logic                  any_zero;
    logic                  unused_i;

    assign go       = !bus.stall && (state == IDLE) && bus.start;
    assign step     = !bus.stall && (state == RUN);
    assign any_zero = (bus.dim_m == '0) || (bus.dim_n == '0) ||
                      (bus.dim_p == '0);
    assign unused_i = ^i;

    loop_counter #(.DIM_WIDTH(DIM_WIDTH)) u_k (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (go),
        .inc   (step),
        .limit (n_q),
        .value (k),
        .last  (k_last)
    );

    loop_counter #(.DIM_WIDTH(DIM_WIDTH)) u_j (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (go),
        .inc   (step && k_last),
        .limit (p_q),
        .value (j),
        .last  (j_last)
    );

    loop_counter #(.DIM_WIDTH(DIM_WIDTH)) u_i (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (go),
        .inc   (step && k_last && j_last),
        .limit (m_q),
        .value (i),
        .last  (i_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            m_q      <= '0;
            n_q      <= '0;
            p_q      <= '0;
            bb_q     <= '0;
            ra       <= '0;
            rb       <= '0;
            rc       <= '0;
            rd_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mac_sr   <= '0;
            first_sr <= '0;
            wr_sr    <= '0;
        end else if (!bus.stall) begin
            // read-side tags travel with the RAM/MAC latency
            mac_sr[0]   <= rd_q;
            first_sr[0] <= rd_q && (k == '0);
            wr_sr[0]    <= rd_q && k_last;
            for (int s = 1; s < RD_LAT; s++) begin
                mac_sr[s]   <= mac_sr[s-1];
                first_sr[s] <= first_sr[s-1];
            end
            for (int s = 1; s < WR_LAT; s++) begin
                wr_sr[s] <= wr_sr[s-1];
            end
            if (wr_sr[WR_LAT-1]) begin
                rc <= rc + ADDR_WIDTH'(1);
            end
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        m_q    <= bus.dim_m;
                        n_q    <= bus.dim_n;
                        p_q    <= bus.dim_p;
                        bb_q   <= bus.base_b;
                        ra     <= bus.base_a;
                        rb     <= bus.base_b;
                        rc     <= bus.base_c;
                        busy_q <= 1'b1;
                        if (any_zero) begin
                            state  <= FIN;
                            done_q <= 1'b1;
                        end else begin
                            state <= RUN;
                            rd_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!k_last) begin
                        ra <= ra + ADDR_WIDTH'(1);
                        rb <= rb + ADDR_WIDTH'(p_q);
                    end else if (!j_last) begin
                        // rewind A to the row start, B to next column
                        ra <= ra - ADDR_WIDTH'(n_q) + ADDR_WIDTH'(1);
                        rb <= bb_q + ADDR_WIDTH'(j) + ADDR_WIDTH'(1);
                    end else begin
                        ra <= ra + ADDR_WIDTH'(1);
                        rb <= bb_q;
                        if (i_last) begin
                            state <= DRAIN;
                            rd_q  <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (wr_sr == WR_TAIL) begin
                        state  <= FIN;
                        done_q <= 1'b1;
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q && !bus.stall;
    assign bus.rd_en     = rd_q && !bus.stall;
    assign bus.addr_a    = ra;
    assign bus.addr_b    = rb;
    assign bus.mac_en    = mac_sr[RD_LAT-1] && !bus.stall;
    assign bus.mac_first = first_sr[RD_LAT-1] && !bus.stall;
    assign bus.wr_en     = wr_sr[WR_LAT-1] && !bus.stall;
    assign bus.addr_c    = rc;

endmodule
